ls161_divider_ctrl: RTL
=======================

Name: ls161_divider_ctrl

Overview:
- Control stage wrapped around a cascade of NSTAGES LS161a 4-bit counter stages, turning the chain into a programmable divide-by-N period timer.
- Drives the chain's D/LOAD_n/ENP/ENT inputs and consumes its Q/RCO outputs.
- Produces one TICK pulse per period, in one-shot or continuous mode.
- Sits between the register/control interface and the counter chain.

Parameters:
- NSTAGES, 4, number of cascaded 4-bit counter stages.
- W, 4*NSTAGES, chain width in bits (derived; not overridden independently).

Ports:
- CLK  in  1  clock, shared with the counter chain.
- CLR  in  1  synchronous active-high reset.
- START  in  1  start/restart request, level sampled each CLK.
- STOP  in  1  stop request, level sampled each CLK.
- MODE  in  1  0 = one-shot, 1 = continuous.
- N  in  W  divide value, sampled only on accepted START; 0 means 2^W.
- CHAIN_Q  in  W  concatenated Q of the chain (stage 0 = LSBs).
- CHAIN_RCO  in  1  RCO of the most significant stage.
- CHAIN_D  out  W  preload value to the chain.
- CHAIN_LOAD_n  out  1  active-low synchronous load to all stages.
- CHAIN_ENP  out  1  count enable (parallel) to all stages.
- CHAIN_ENT  out  1  count enable (trickle) to stage 0.
- CHAIN_CLR_n  out  1  equals ~CLR.
- TICK  out  1  one-cycle pulse at terminal count of each period.
- BUSY  out  1  high in PRELOAD and RUN.
- DONE  out  1  registered one-cycle pulse after a one-shot period completes.
- TICKS  out  8  saturating count of TICKs since the last accepted START.

Behaviour:
- Reset, synchronous: on a CLK edge with CLR=1, state <= IDLE, n_lat <= 0, mode_lat <= 0, DONE <= 0, TICKS <= 0. CLR overrides all other inputs.
- CHAIN_CLR_n = ~CLR, combinational, so the chain clears on the same edge.
- Preload value P = (2^W - n_lat) mod 2^W, computed in W bits. CHAIN_D = P at all times.
- Period: the chain counts P .. 2^W-1, which is n_lat states, then reloads.
  - n_lat = 1 gives P = all-ones: RCO every cycle, period 1.
  - n_lat = 0 gives P = 0: period 2^W.
- States:
  - IDLE: LOAD_n=1, ENP=ENT=0, so the chain holds its value.
    - START=1 and STOP=0: latch n_lat<=N, mode_lat<=MODE, TICKS<=0, go to PRELOAD.
  - PRELOAD: LOAD_n=0, ENP=ENT=0. The chain loads P on this edge; go to RUN.
  - RUN: ENP=ENT=1.
    - terminal = CHAIN_RCO, equivalent to CHAIN_Q == all-ones with ENT=1.
    - On terminal: TICK=1 combinationally and TICKS increments, saturating at 255.
    - Continuous: on terminal, LOAD_n=0 so the chain reloads P on the same edge; stay in RUN.
    - One-shot: on terminal, LOAD_n=1 and ENP=0 this same cycle, so the chain holds at all-ones. Go to IDLE; DONE=1 for the next cycle.
- Priority in RUN and PRELOAD: CLR > STOP > START > terminal.
  - STOP=1: go to IDLE next edge. ENP/ENT=0 and LOAD_n=1 this cycle, so the chain holds. No TICK, no DONE, even if terminal coincides.
  - START=1 and STOP=0: restart. Re-latch N/MODE, TICKS<=0, go to PRELOAD. No TICK is emitted that cycle.
  - START and STOP together in any state: STOP wins; START is ignored.
- Latency: TICK asserts n_lat cycles after the PRELOAD edge, then every n_lat cycles in continuous mode.
- N changes while BUSY have no effect until the next accepted START.
- BUSY = (state != IDLE). TICK is forced 0 outside RUN.

Decomposition:
- Shared package ls161_pkg holds:
  - state typedef {IDLE, PRELOAD, RUN};
  - MODE_ONESHOT / MODE_CONT constants;
  - TICKS_MAX = 8'hFF.
- No RTL sub-module is needed; the FSM and the preload arithmetic are one block.
- The bench instantiates NSTAGES LS161a stages as the chain:
  - RCO of stage k drives ENT of stage k+1;
  - ENP and LOAD_n are shared across stages;
  - D is sliced 4 bits per stage.

Test Plan:
- CLR=1 for 2 cycles with START=1 -> state IDLE, BUSY=0, TICKS=0, CHAIN_CLR_n=0; chain Q=0 after release.
- W=16, MODE=1, N=5, one-cycle START -> PRELOAD loads 0xFFFB; TICK every 5 cycles; TICKS=3 after 3 periods; BUSY stays 1.
- MODE=0, N=3, START -> one TICK 3 cycles after the load; DONE pulses 1 cycle later; BUSY=0; chain holds 0xFFFF.
- MODE=1, N=1 -> TICK high every cycle in RUN; N=0 -> first TICK after exactly 65536 cycles.
- STOP asserted in RUN in the same cycle as terminal -> no TICK, no DONE, IDLE next; chain Q frozen at 0xFFFF.
- START with N=4 while RUN with N=10 at Q=0xFFF8 -> PRELOAD next, reload 0xFFFC, TICKS cleared, TICK 4 cycles later.
- START and STOP together from IDLE -> remains IDLE.

Source files
------------

// File: rtl/ls161_pkg.sv
// Shared types and constants for the LS161 divide-by-N control stage.
package ls161_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRELOAD = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

  localparam int unsigned TICKS_W   = 8;
  localparam logic [7:0]  TICKS_MAX = 8'hFF;

endpackage

// File: rtl/ls161_divider_ctrl.sv
// Control stage that turns a cascade of LS161a counters into a divide-by-N timer.
// The chain is preloaded with 2^W - N and counts up to all-ones; RCO marks the
// end of each period.
module ls161_divider_ctrl
  import ls161_pkg::*;
#(
  parameter  int unsigned NSTAGES = 4,
  localparam int unsigned W       = 4 * NSTAGES
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               START,
  input  logic               STOP,
  input  logic               MODE,
  input  logic [W-1:0]       N,
  input  logic [W-1:0]       CHAIN_Q,
  input  logic               CHAIN_RCO,
  output logic [W-1:0]       CHAIN_D,
  output logic               CHAIN_LOAD_n,
  output logic               CHAIN_ENP,
  output logic               CHAIN_ENT,
  output logic               CHAIN_CLR_n,
  output logic               TICK,
  output logic               BUSY,
  output logic               DONE,
  output logic [TICKS_W-1:0] TICKS
);

  state_t               state, state_nxt;
  logic [W-1:0]         n_lat;
  logic                 mode_lat;
  logic                 done_q;
  logic [TICKS_W-1:0]   ticks_q;

  logic                 latch_c;
  logic                 done_nxt;
  logic                 terminal;

  // RCO already implies ENT and Q all-ones; qualifying with Q keeps CHAIN_Q meaningful
  assign terminal = CHAIN_RCO && (&CHAIN_Q);

  // Preload so that the chain spends exactly n_lat states before all-ones (0 -> 2^W)
  assign CHAIN_D     = W'(0) - n_lat;
  assign CHAIN_CLR_n = ~CLR;
  assign BUSY        = (state != IDLE);
  assign DONE        = done_q;
  assign TICKS       = ticks_q;

  // State and datapath registers, synchronous clear
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state    <= IDLE;
      n_lat    <= '0;
      mode_lat <= MODE_ONESHOT;
      done_q   <= 1'b0;
      ticks_q  <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      if (latch_c) begin
        n_lat    <= N;
        mode_lat <= MODE;
        ticks_q  <= '0;
      end else if (TICK && (ticks_q != TICKS_MAX)) begin
        ticks_q <= ticks_q + TICKS_W'(1);
      end
    end
  end

  // Next-state and chain control; STOP beats START beats terminal
  always_comb begin
    state_nxt    = state;
    CHAIN_LOAD_n = 1'b1;
    CHAIN_ENP    = 1'b0;
    CHAIN_ENT    = 1'b0;
    TICK         = 1'b0;
    latch_c      = 1'b0;
    done_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (START && !STOP) begin
          latch_c   = 1'b1;
          state_nxt = PRELOAD;
        end
      end

      PRELOAD: begin
        if (STOP) begin
          state_nxt = IDLE;
        end else if (START) begin
          latch_c   = 1'b1;
          state_nxt = PRELOAD;
        end else begin
          CHAIN_LOAD_n = 1'b0;
          state_nxt    = RUN;
        end
      end

      RUN: begin
        if (STOP) begin
          state_nxt = IDLE;
        end else if (START) begin
          latch_c   = 1'b1;
          state_nxt = PRELOAD;
        end else begin
          CHAIN_ENP = 1'b1;
          CHAIN_ENT = 1'b1;
          if (terminal) begin
            TICK = 1'b1;
            if (mode_lat == MODE_CONT) begin
              CHAIN_LOAD_n = 1'b0;
            end else begin
              // freeze the chain at all-ones and finish the one-shot period
              CHAIN_ENP = 1'b0;
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
